// File: rtl/redirect_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | redirect_ctl : sequences trap / branch / fence.i redirects into fetch,    |
// |                draining outstanding requests and invalidating the icache. |
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
module redirect_ctl #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_en,
  input  logic [63:0] trap_pc,
  input  logic        bj_en,
  input  logic [63:0] bj_pc,
  input  logic        fencei_en,
  input  logic [63:0] fencei_pc,
  input  logic        fetch_req_fire,
  input  logic        fetch_rsp_valid,
  input  logic        icache_inv_ack,
  output logic        redir_en,
  output logic [63:0] redir_pc,
  output logic        fetch_hold,
  output logic        rsp_kill,
  output logic        icache_inv_req,
  output logic        busy
);

  localparam int CNT_W = (MAX_OUT < 1) ? 1 : $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_INV   = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [63:0]      pend_pc;
  logic [63:0]      pend_pc_nxt;
  logic             pend_inv;
  logic             pend_inv_nxt;
  logic             any_redir;
  logic             accept;
  logic [63:0]      sel_pc;
  logic             sel_inv;
  logic [1:0]       route;

  // Outstanding-request counter: saturating, never underflows.
  always_comb begin
    cnt_nxt = out_cnt;
    if (fetch_req_fire && !fetch_rsp_valid) begin
      if (out_cnt != CNT_MAX) cnt_nxt = out_cnt + 1'b1;
    end else if (!fetch_req_fire && fetch_rsp_valid) begin
      if (out_cnt != '0) cnt_nxt = out_cnt - 1'b1;
    end
  end

  always_comb begin
    any_redir = trap_en | bj_en | fencei_en;
    sel_pc    = fencei_pc;
    sel_inv   = 1'b1;
    if (trap_en) begin
      sel_pc  = trap_pc;
      sel_inv = 1'b0;
    end else if (bj_en) begin
      sel_pc  = bj_pc;
      sel_inv = 1'b0;
    end
  end

  // Outside IDLE only a trap may retarget; bj/fence.i there are wrong-path.
  always_comb begin
    accept       = (state == S_IDLE) ? any_redir : trap_en;
    pend_pc_nxt  = accept ? sel_pc  : pend_pc;
    pend_inv_nxt = accept ? sel_inv : pend_inv;
    if (cnt_nxt != '0)     route = S_DRAIN;
    else if (pend_inv_nxt) route = S_INV;
    else                   route = S_ISSUE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_redir) state_nxt = route;
      S_DRAIN: state_nxt = route;
      S_INV:   if (icache_inv_ack) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = trap_en ? route : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_cnt  <= '0;
      pend_pc  <= '0;
      pend_inv <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_cnt  <= cnt_nxt;
      pend_pc  <= pend_pc_nxt;
      pend_inv <= pend_inv_nxt;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once.
  always_comb begin
    busy           = (state != S_IDLE);
    fetch_hold     = busy | any_redir;
    rsp_kill       = fetch_hold;
    icache_inv_req = (state == S_INV);
    redir_en       = (state == S_ISSUE) & ~trap_en;
    redir_pc       = redir_en ? pend_pc : 64'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_redirect_ctl : directed self-checking bench for redirect_ctl.          |
// | Revision        : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_redirect_ctl;

  logic        clk;
  logic        rst_n;
  logic        trap_en;
  logic [63:0] trap_pc;
  logic        bj_en;
  logic [63:0] bj_pc;
  logic        fencei_en;
  logic [63:0] fencei_pc;
  logic        fetch_req_fire;
  logic        fetch_rsp_valid;
  logic        icache_inv_ack;
  logic        redir_en;
  logic [63:0] redir_pc;
  logic        fetch_hold;
  logic        rsp_kill;
  logic        icache_inv_req;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  redirect_ctl #(.MAX_OUT(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trap_en         (trap_en),
    .trap_pc         (trap_pc),
    .bj_en           (bj_en),
    .bj_pc           (bj_pc),
    .fencei_en       (fencei_en),
    .fencei_pc       (fencei_pc),
    .fetch_req_fire  (fetch_req_fire),
    .fetch_rsp_valid (fetch_rsp_valid),
    .icache_inv_ack  (icache_inv_ack),
    .redir_en        (redir_en),
    .redir_pc        (redir_pc),
    .fetch_hold      (fetch_hold),
    .rsp_kill        (rsp_kill),
    .icache_inv_req  (icache_inv_req),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs return to idle just after the edge.
  task automatic nc();
    @(posedge clk);
    #1;
    trap_en = 0; trap_pc = '0; bj_en = 0; bj_pc = '0;
    fencei_en = 0; fencei_pc = '0;
    fetch_req_fire = 0; fetch_rsp_valid = 0; icache_inv_ack = 0;
  endtask

  initial begin
    rst_n = 0;
    trap_en = 0; trap_pc = '0; bj_en = 0; bj_pc = '0;
    fencei_en = 0; fencei_pc = '0;
    fetch_req_fire = 0; fetch_rsp_valid = 0; icache_inv_ack = 0;
    #2;
    check("rst_redir_en", redir_en, 0);
    check("rst_redir_pc", redir_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_inv_req", icache_inv_req, 0);
    check("rst_hold", fetch_hold, 0);
    check("rst_cnt", dut.out_cnt, 0);
    nc(); nc();
    rst_n = 1;

    // Branch with nothing outstanding: minimum latency
    nc(); bj_en = 1; bj_pc = 64'h8000_0100; #1;
    check("bj_hold_T", fetch_hold, 1);
    check("bj_kill_T", rsp_kill, 1);
    check("bj_redir_T", redir_en, 0);
    nc(); #1;
    check("bj_redir_T1", redir_en, 1);
    check("bj_pc_T1", redir_pc, 64'h8000_0100);
    nc(); #1;
    check("bj_redir_T2", redir_en, 0);
    check("bj_pc_T2", redir_pc, 0);
    check("bj_busy_T2", busy, 0);

    // Trap with two outstanding requests; wrong-path branch during drain
    nc(); fetch_req_fire = 1;
    nc(); fetch_req_fire = 1;
    nc(); trap_en = 1; trap_pc = 64'h1000; #1;
    check("drain_kill_T", rsp_kill, 1);
    nc(); #1;
    check("drain_cnt_T1", dut.out_cnt, 2);
    check("drain_busy_T1", busy, 1);
    nc(); fetch_rsp_valid = 1; #1;
    check("drain_kill_T2", rsp_kill, 1);
    check("drain_redir_T2", redir_en, 0);
    nc(); bj_en = 1; bj_pc = 64'hDEAD; #1;
    check("drain_cnt_T3", dut.out_cnt, 1);
    check("drain_busy_T3", busy, 1);
    nc(); fetch_rsp_valid = 1; #1;
    check("drain_kill_T4", rsp_kill, 1);
    check("drain_redir_T4", redir_en, 0);
    nc(); #1;
    check("drain_redir_T5", redir_en, 1);
    check("drain_pc_T5", redir_pc, 64'h1000);
    nc(); #1;
    check("drain_idle_T6", busy, 0);

    // fence.i: invalidate then redirect
    nc(); fencei_en = 1; fencei_pc = 64'h2004; #1;
    check("fi_inv_T", icache_inv_req, 0);
    nc(); #1;
    check("fi_inv_T1", icache_inv_req, 1);
    nc(); #1;
    check("fi_inv_T2", icache_inv_req, 1);
    nc(); icache_inv_ack = 1; #1;
    check("fi_inv_T3", icache_inv_req, 1);
    check("fi_redir_T3", redir_en, 0);
    nc(); #1;
    check("fi_redir_T4", redir_en, 1);
    check("fi_pc_T4", redir_pc, 64'h2004);
    check("fi_inv_T4", icache_inv_req, 0);
    nc(); #1;
    check("fi_idle_T5", busy, 0);

    // Trap during INV keeps invalidate until ack, then trap target
    nc(); fencei_en = 1; fencei_pc = 64'h3000;
    nc(); trap_en = 1; trap_pc = 64'h1000; #1;
    check("tinv_inv_T1", icache_inv_req, 1);
    nc(); #1;
    check("tinv_inv_T2", icache_inv_req, 1);
    nc(); icache_inv_ack = 1;
    nc(); #1;
    check("tinv_redir", redir_en, 1);
    check("tinv_pc", redir_pc, 64'h1000);

    // Trap in ISSUE suppresses the pulse and re-issues with trap target
    nc(); bj_en = 1; bj_pc = 64'h7000;
    nc(); trap_en = 1; trap_pc = 64'h6000; #1;
    check("tiss_redir_T1", redir_en, 0);
    check("tiss_pc_T1", redir_pc, 0);
    nc(); #1;
    check("tiss_redir_T2", redir_en, 1);
    check("tiss_pc_T2", redir_pc, 64'h6000);
    nc(); #1;
    check("tiss_idle_T3", busy, 0);

    // Priority: trap over bj
    nc(); trap_en = 1; trap_pc = 64'h4000; bj_en = 1; bj_pc = 64'h5000;
    nc(); #1;
    check("prio_pc", redir_pc, 64'h4000);

    // Counter: fire+rsp unchanged, no underflow, saturation
    nc(); fetch_req_fire = 1;
    nc(); fetch_req_fire = 1; fetch_rsp_valid = 1;
    nc(); #1;
    check("cnt_both", dut.out_cnt, 1);
    fetch_rsp_valid = 1;
    nc(); fetch_rsp_valid = 1;
    nc(); #1;
    check("cnt_underflow", dut.out_cnt, 0);
    fetch_req_fire = 1;
    nc(); fetch_req_fire = 1;
    nc(); fetch_req_fire = 1;
    nc(); #1;
    check("cnt_sat", dut.out_cnt, 2);

    // Reset while draining with two outstanding
    trap_en = 1; trap_pc = 64'h9000;
    nc(); #1;
    check("rdrain_busy", busy, 1);
    rst_n = 0; #1;
    check("rdrain_busy_rst", busy, 0);
    check("rdrain_cnt_rst", dut.out_cnt, 0);
    nc(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      nc(); #1;
      check("rdrain_no_redir", redir_en, 0);
    end
    check("rdrain_idle", busy, 0);

    // Reset while invalidating drops the request immediately
    nc(); fencei_en = 1; fencei_pc = 64'hA000;
    nc(); #1;
    check("rinv_inv", icache_inv_req, 1);
    rst_n = 0; #1;
    check("rinv_inv_rst", icache_inv_req, 0);
    nc(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      nc(); #1;
      check("rinv_no_redir", redir_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/redirect_ctl.md
REDIRECT_CTL -- requirements
Module: redirect_ctl

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of outstanding fetch requests tracked.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 trap_en / trap_pc  input  1 / 64  trap redirect request and target.
REQ-005 bj_en / bj_pc  input  1 / 64  branch/jump redirect request and target.
REQ-006 fencei_en / fencei_pc  input  1 / 64  fence.i redirect request and target; requires icache invalidate.
REQ-007 fetch_req_fire  input  1  fetch request accepted by memory this cycle.
REQ-008 fetch_rsp_valid  input  1  fetch response returned this cycle.
REQ-009 icache_inv_ack  input  1  icache invalidate complete, single-cycle pulse.
REQ-010 redir_en / redir_pc  output  1 / 64  single-cycle redirect to the PC register.
REQ-011 fetch_hold  output  1  fetch shall not issue new requests.
REQ-012 rsp_kill  output  1  fetch shall discard any response this cycle.
REQ-013 icache_inv_req  output  1  level request to invalidate icache.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Outstanding counter out_cnt, width clog2(MAX_OUT+1): +1 on fire only, -1 on rsp only, unchanged on both or neither.
REQ-016 out_cnt SHALL saturate at MAX_OUT and SHALL NOT underflow; a rsp with out_cnt==0 is ignored.
REQ-017 Redirect priority: trap > bj > fencei; one selected per cycle into pend_pc and pend_inv (pend_inv=1 only for fencei).
REQ-018 States: IDLE, DRAIN, INV, ISSUE.
REQ-019 IDLE with any redirect at cycle T: capture, then go to DRAIN if next out_cnt != 0; otherwise INV if pend_inv, else ISSUE.
REQ-020 DRAIN: stay while out_cnt != 0, counting responses; when next out_cnt is 0, go to INV if pend_inv, else ISSUE.
REQ-021 INV: assert icache_inv_req; on icache_inv_ack go to ISSUE.
REQ-022 ISSUE: assert redir_en=1 with redir_pc=pend_pc for exactly one cycle, then go to IDLE.
REQ-023 Minimum latency: redirect at T with out_cnt 0 and no fire gives redir_en at T+1.
REQ-024 fetch_hold = (state != IDLE) | trap_en | bj_en | fencei_en.
REQ-025 rsp_kill follows the same equation as fetch_hold.
REQ-026 Trap in DRAIN overwrites pend_pc and clears pend_inv; the state rules of REQ-020 continue.
REQ-027 Trap in INV overwrites pend_pc and clears pend_inv; icache_inv_req stays high until ack, then ISSUE with the trap pc.
REQ-028 Trap in ISSUE suppresses redir_en that cycle, captures trap_pc, and applies the REQ-019 next-state rule.
REQ-029 bj_en or fencei_en when state != IDLE SHALL be ignored as wrong-path.
REQ-030 redir_pc SHALL be 0 whenever redir_en is 0.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, out_cnt 0, pend_pc 0, pend_inv 0, all outputs 0 except combinational fetch_hold/rsp_kill.
REQ-032 Reset mid-operation (any state) SHALL abandon the pending redirect with no redir_en pulse after release; icache_inv_req drops at once.

Verification
REQ-033 out_cnt 0, bj_en=1, bj_pc=0x8000_0100 at T -> fetch_hold=1 and rsp_kill=1 at T; redir_en=1, redir_pc=0x8000_0100 at T+1 only.
REQ-034 Two fires, then trap_pc=0x1000; rsp at T+2 and T+4 -> DRAIN through T+4, rsp_kill high on both responses, redir_en at T+5 with 0x1000.
REQ-035 fencei_en, fencei_pc=0x2004, out_cnt 0 -> icache_inv_req from T+1; ack at T+3 -> redir_en at T+4 with 0x2004.
REQ-036 During INV, trap_pc=0x1000 -> icache_inv_req held until ack, then redir_en with 0x1000; a bj_en during DRAIN leaves pend_pc unchanged.
REQ-037 trap_en and bj_en in the same cycle -> trap_pc selected; fire and rsp in the same cycle leave out_cnt unchanged; rsp at out_cnt 0 leaves it at 0.
REQ-038 rst_n asserted in DRAIN with out_cnt 2 -> after release: IDLE, out_cnt 0, no redir_en pulse.
